// File: rtl/digit_editor_pkg.sv
// Shared types and constants for the HH:MM digit editor.
// Digit indices, per-digit limits and the auto-repeat FSM encoding.
package digit_editor_pkg;

  typedef logic [3:0] bcd_t;

  localparam int DIG_MO = 0;
  localparam int DIG_MT = 1;
  localparam int DIG_HO = 2;
  localparam int DIG_HT = 3;

  localparam bcd_t MAX_MO    = 4'd9;
  localparam bcd_t MAX_MT    = 4'd5;
  localparam bcd_t MAX_HO    = 4'd9;
  localparam bcd_t MAX_HO_24 = 4'd3;
  localparam bcd_t MAX_HT    = 4'd2;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  function automatic bcd_t ho_max(bcd_t ht);
    return (ht == MAX_HT) ? MAX_HO_24 : MAX_HO;
  endfunction

  function automatic bcd_t clamp(bcd_t v, bcd_t mx);
    return (v > mx) ? mx : v;
  endfunction

  // Wrapping step within 0..mx, no carry out.
  function automatic bcd_t bump(bcd_t v, bcd_t mx, logic inc);
    if (inc)
      return (v >= mx) ? 4'd0 : v + 4'd1;
    return (v == 4'd0) ? mx : v - 4'd1;
  endfunction

endpackage

// File: rtl/digit_editor_btn_repeat.sv
// Button edge detect plus hold-delay / auto-repeat step generator.
// A button held through reset must be released before it steps again.
import digit_editor_pkg::*;

module btn_repeat #(
  parameter int HOLD   = 50,
  parameter int PERIOD = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic en,
  output logic step
);

  localparam int CW = $clog2(HOLD + PERIOD + 1);

  rpt_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q, prev_d;
  logic          arm_q, arm_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    prev_d  = btn;
    arm_d   = arm_q | ~btn;
    if (!btn || !en) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RPT_IDLE: begin
          if (!prev_q && arm_q) begin
            step    = 1'b1;
            state_d = RPT_DELAY;
            cnt_d   = CW'(1);
          end
        end
        RPT_DELAY: begin
          if (cnt_q == CW'(HOLD)) begin
            step    = 1'b1;
            state_d = RPT_REPEAT;
            cnt_d   = CW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RPT_REPEAT: begin
          if (cnt_q == CW'(PERIOD)) begin
            step  = 1'b1;
            cnt_d = CW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
    end
  end

endmodule

// File: rtl/digit_editor.sv
// HH:MM BCD digit editor with up/down auto-repeat, load and commit.
// Digits wrap independently; hour ones follows the 24h limit.
import digit_editor_pkg::*;

module digit_editor #(
  parameter int HOLD_DELAY    = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sel,
  input  logic        active,
  input  logic        up,
  input  logic        down,
  input  logic        load,
  input  logic [15:0] load_time,
  input  logic        commit,
  output logic [15:0] edit_time,
  output logic [15:0] time_out,
  output logic        time_valid,
  output logic        dirty
);

  logic [15:0] edit_q, edit_d;
  logic [15:0] tout_q, tout_d;
  logic        valid_q, valid_d;
  logic        dirty_q, dirty_d;
  logic        up_step, down_step;
  logic        btn_en, sel_ok;
  bcd_t        mo, mt, ho, ht, ht_n;

  // Pressing both buttons cancels both repeaters.
  assign btn_en = active & ~(up & down);
  assign sel_ok = (sel[7:4] == 4'd0) && $onehot(sel[3:0]);

  btn_repeat #(
    .HOLD   (HOLD_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_up (
    .clk   (clk),
    .reset (reset),
    .btn   (up),
    .en    (btn_en),
    .step  (up_step)
  );

  btn_repeat #(
    .HOLD   (HOLD_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_down (
    .clk   (clk),
    .reset (reset),
    .btn   (down),
    .en    (btn_en),
    .step  (down_step)
  );

  always_comb begin
    mo     = edit_q[3:0];
    mt     = edit_q[7:4];
    ho     = edit_q[11:8];
    ht     = edit_q[15:12];
    ht_n   = ht;
    edit_d = edit_q;
    if (load) begin
      ht_n           = clamp(load_time[15:12], MAX_HT);
      edit_d[15:12]  = ht_n;
      edit_d[11:8]   = clamp(load_time[11:8], ho_max(ht_n));
      edit_d[7:4]    = clamp(load_time[7:4], MAX_MT);
      edit_d[3:0]    = clamp(load_time[3:0], MAX_MO);
    end else if (sel_ok && (up_step || down_step)) begin
      unique case (1'b1)
        sel[DIG_MO]: edit_d[3:0]  = bump(mo, MAX_MO, up_step);
        sel[DIG_MT]: edit_d[7:4]  = bump(mt, MAX_MT, up_step);
        sel[DIG_HO]: edit_d[11:8] = bump(ho, ho_max(ht), up_step);
        sel[DIG_HT]: begin
          ht_n          = bump(ht, MAX_HT, up_step);
          edit_d[15:12] = ht_n;
          if (ht_n == MAX_HT && ho > MAX_HO_24)
            edit_d[11:8] = MAX_HO_24;
        end
        default: ;
      endcase
    end
  end

  // Commit publishes the value held before this edge's step.
  always_comb begin
    tout_d  = commit ? edit_q : tout_q;
    valid_d = commit;
    if (!load && edit_d != edit_q)
      dirty_d = 1'b1;
    else if (load || commit)
      dirty_d = 1'b0;
    else
      dirty_d = dirty_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edit_q  <= 16'h0000;
      tout_q  <= 16'h0000;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      edit_q  <= edit_d;
      tout_q  <= tout_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  assign edit_time  = edit_q;
  assign time_out   = tout_q;
  assign time_valid = valid_q;
  assign dirty      = dirty_q;

endmodule
